button_entry: RTL and testbench
===============================

Name: button_entry

Overview:
- Operator-input block: turns two debounced push-buttons into an edited WIDTH-bit value with a commit strobe.
- It is the writer counterpart to the debug display path. That path shows register values on the LEDs; this block lets the operator enter a value with the same two buttons and watch it on the same LEDs.
- Sits after the button debouncers. Drives a target register and the LED bank (o_display).

Parameters:
- WIDTH, 8, width of the edited/committed value.
- BLINK_HALF, 1024*1024*25, cycles per half-period of the cursor-bit blink (>=2).
- ABORT_CYCLES, 1024*1024*100, hold length (cycles) after which a press episode is discarded (>=2).
- RESET_VALUE, 0, reset value of o_value and o_working.

Ports:
- clk  in  1  clock
- i_reset  in  1  synchronous reset, active-low
- i_buttons  in  2  debounced buttons, active-high; [0]=toggle, [1]=advance
- o_working  out  WIDTH  value being edited
- o_value  out  WIDTH  last committed value
- o_valid  out  1  one-cycle strobe; o_value updated
- o_cursor  out  $clog2(WIDTH)  selected bit index
- o_display  out  WIDTH  o_working with the cursor bit blinking, for LEDs

Behaviour:
- Reset (i_reset==0 at a clk edge):
  - o_working=o_value=RESET_VALUE, o_cursor=0, o_valid=0.
  - Blink counter=0, phase=0, hold counter=0, press mask=00, state=WAIT_RELEASE.
  - Reset mid-press discards the episode with no action.
- FSM states are IDLE, PRESS and WAIT_RELEASE. i_buttons is sampled directly every edge.
- WAIT_RELEASE: stays until i_buttons==00, then goes to IDLE. A button held through reset or abort never causes an action.
- IDLE: if i_buttons!=00, go to PRESS, with mask<=i_buttons and hold counter<=1.
- PRESS, each edge:
  - mask<=mask|i_buttons; hold counter increments.
  - If i_buttons==00 at an edge, the action is decoded from the accumulated mask and applied at that same edge; state goes to IDLE.
  - If hold counter reaches ABORT_CYCLES while any button is still high: go to WAIT_RELEASE, mask cleared, no action.
- Actions (mask at release):
  - 01: o_working[o_cursor] inverted.
  - 10: o_cursor<=o_cursor+1, wrapping WIDTH-1 -> 0. Wrap is explicit for non-power-of-2 WIDTH.
  - 11 (chord, both buttons high at any point in the episode, not necessarily together): o_value<=o_working and o_cursor<=0. o_working is unchanged. o_valid is high during exactly the cycle after that edge.
- o_valid: registered. Never high for two consecutive cycles. Low whenever no commit occurred.
- Blink:
  - Free-running counter 0..BLINK_HALF-1; phase toggles on wrap.
  - Counter and phase clear to 0 at any edge where o_cursor changes, so the newly selected bit starts unblinked.
  - o_display = o_working XOR (phase << o_cursor), combinational from registers.
- Minimum episode length is 1 cycle: buttons high for one sample then 00 yields one action.
- No action ever occurs in IDLE or WAIT_RELEASE. At most one action per episode.

Test Plan (WIDTH=8, BLINK_HALF=4, ABORT_CYCLES=16, RESET_VALUE=0):
- Reset with buttons=00, then 2 idle cycles -> all outputs 0. o_display toggles bit0 every 4 cycles: 00,01,00. o_valid stays 0.
- Press [0] for 3 cycles, release; then [1] 3 cycles, release; then [0] 3 cycles, release.
  - o_working=0x01 on the edge that samples the first release.
  - Then o_cursor=1 with blink counter cleared.
  - Then o_working=0x03. o_value=0, o_valid never high.
- Press [1] 8 times (each 2 cycles on / 2 off) from cursor 0 -> o_cursor goes 1..7 then wraps to 0.
- Set o_working=0x03, then press [0], add [1] two cycles later, drop [0], drop [1] -> single commit: o_value=0x03, o_cursor=0, o_valid high exactly 1 cycle, o_working still 0x03, no toggle/advance.
- Hold [0] for 20 cycles, release -> state enters WAIT_RELEASE at cycle 16. o_working unchanged, no action on release. The next short [0] press toggles normally.
- Hold [1] while asserting i_reset=0 for 2 cycles, deassert, keep [1] held 5 more cycles, release -> outputs at reset values, no cursor advance. The following [1] press advances o_cursor to 1.

Source files
------------

// File: rtl/button_entry.sv
// Two-button value editor: [0] toggles the cursor bit, [1] advances the cursor, a chord commits.
// The cursor bit blinks on o_display so the operator can see which bit is selected.
module button_entry #(
    parameter int unsigned      WIDTH        = 8,
    parameter int unsigned      BLINK_HALF   = 1024 * 1024 * 25,
    parameter int unsigned      ABORT_CYCLES = 1024 * 1024 * 100,
    parameter logic [WIDTH-1:0] RESET_VALUE  = '0
) (
    input  logic                     clk,
    input  logic                     i_reset,
    input  logic [1:0]               i_buttons,
    output logic [WIDTH-1:0]         o_working,
    output logic [WIDTH-1:0]         o_value,
    output logic                     o_valid,
    output logic [$clog2(WIDTH)-1:0] o_cursor,
    output logic [WIDTH-1:0]         o_display
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam int unsigned BW = $clog2(BLINK_HALF);
    localparam int unsigned HW = $clog2(ABORT_CYCLES + 1);

    typedef enum logic [1:0] {StIdle, StPress, StWaitRelease} state_e;

    state_e           state_q, state_d;
    logic [1:0]       mask_q, mask_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic [WIDTH-1:0] working_q, working_d;
    logic [WIDTH-1:0] value_q, value_d;
    logic             valid_q, valid_d;
    logic [CW-1:0]    cursor_q, cursor_d;
    logic [BW-1:0]    blink_q, blink_d;
    logic             phase_q, phase_d;

    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        hold_d    = hold_q;
        working_d = working_q;
        value_d   = value_q;
        valid_d   = 1'b0;
        cursor_d  = cursor_q;

        case (state_q)
            StWaitRelease: begin
                if (i_buttons == 2'b00) begin
                    state_d = StIdle;
                end
            end
            StIdle: begin
                if (i_buttons != 2'b00) begin
                    state_d = StPress;
                    mask_d  = i_buttons;
                    hold_d  = HW'(1);
                end
            end
            StPress: begin
                if (i_buttons == 2'b00) begin
                    // Release: act on everything seen during the episode.
                    state_d = StIdle;
                    mask_d  = 2'b00;
                    hold_d  = '0;
                    case (mask_q)
                        2'b01: working_d = working_q ^ (WIDTH'(1) << cursor_q);
                        2'b10: cursor_d = (cursor_q == CW'(WIDTH - 1)) ? '0 : cursor_q + CW'(1);
                        2'b11: begin
                            value_d  = working_q;
                            cursor_d = '0;
                            valid_d  = 1'b1;
                        end
                        default: ;
                    endcase
                end else if (hold_q == HW'(ABORT_CYCLES - 1)) begin
                    state_d = StWaitRelease;
                    mask_d  = 2'b00;
                    hold_d  = '0;
                end else begin
                    mask_d = mask_q | i_buttons;
                    hold_d = hold_q + HW'(1);
                end
            end
            default: state_d = StWaitRelease;
        endcase
    end

    // A newly selected bit always starts in the unblinked phase.
    always_comb begin
        blink_d = blink_q;
        phase_d = phase_q;
        if (cursor_d != cursor_q) begin
            blink_d = '0;
            phase_d = 1'b0;
        end else if (blink_q == BW'(BLINK_HALF - 1)) begin
            blink_d = '0;
            phase_d = ~phase_q;
        end else begin
            blink_d = blink_q + BW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!i_reset) begin
            state_q   <= StWaitRelease;
            mask_q    <= 2'b00;
            hold_q    <= '0;
            working_q <= RESET_VALUE;
            value_q   <= RESET_VALUE;
            valid_q   <= 1'b0;
            cursor_q  <= '0;
            blink_q   <= '0;
            phase_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            hold_q    <= hold_d;
            working_q <= working_d;
            value_q   <= value_d;
            valid_q   <= valid_d;
            cursor_q  <= cursor_d;
            blink_q   <= blink_d;
            phase_q   <= phase_d;
        end
    end

    assign o_working = working_q;
    assign o_value   = value_q;
    assign o_valid   = valid_q;
    assign o_cursor  = cursor_q;
    assign o_display = working_q ^ (WIDTH'(phase_q) << cursor_q);

endmodule

// File: tb/tb_button_entry.sv
// Directed bench for button_entry: expected outputs are queued as stimulus is driven and
// compared after the clock edge that should produce them.
module tb_button_entry;

    logic       clk = 1'b0;
    logic       i_reset = 1'b0;
    logic [1:0] i_buttons = 2'b00;
    logic [7:0] o_working, o_value, o_display;
    logic       o_valid;
    logic [2:0] o_cursor;

    int   errors = 0;
    int   checks = 0;
    logic exp_valid = 1'b0;

    typedef struct {
        string      tag;
        logic [7:0] w;
        logic [7:0] v;
        logic [2:0] c;
    } exp_t;

    exp_t sb[$];

    button_entry #(
        .WIDTH       (8),
        .BLINK_HALF  (4),
        .ABORT_CYCLES(16),
        .RESET_VALUE (8'h00)
    ) dut (
        .clk      (clk),
        .i_reset  (i_reset),
        .i_buttons(i_buttons),
        .o_working(o_working),
        .o_value  (o_value),
        .o_valid  (o_valid),
        .o_cursor (o_cursor),
        .o_display(o_display)
    );

    always #5 clk = ~clk;

    task automatic push(input string tag, input logic [7:0] w, input logic [7:0] v,
                        input logic [2:0] c);
        exp_t e;
        e.tag = tag;
        e.w   = w;
        e.v   = v;
        e.c   = c;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            assert (o_working === e.w && o_value === e.v && o_cursor === e.c)
            else begin
                errors++;
                $error("FAIL %s: got working=%h value=%h cursor=%0d, expected working=%h value=%h cursor=%0d",
                       e.tag, o_working, o_value, o_cursor, e.w, e.v, e.c);
            end
        end
    endtask

    task automatic chk_disp(input string tag, input logic [7:0] exp);
        checks++;
        assert (o_display === exp)
        else begin
            errors++;
            $error("FAIL %s: got display=%h, expected %h", tag, o_display, exp);
        end
    endtask

    // One clock edge with the given buttons, then check o_valid and any queued expectations.
    task automatic tick(input logic [1:0] b);
        i_buttons = b;
        @(posedge clk);
        #1;
        checks++;
        assert (o_valid === exp_valid)
        else begin
            errors++;
            $error("FAIL valid: got %b, expected %b", o_valid, exp_valid);
        end
        drain();
        exp_valid = 1'b0;
    endtask

    initial begin
        // Reset and idle blinking of bit 0.
        tick(2'b00);
        push("reset", 8'h00, 8'h00, 3'd0);
        tick(2'b00);
        chk_disp("reset display", 8'h00);
        i_reset = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            if (i == 2) push("idle outputs", 8'h00, 8'h00, 3'd0);
            tick(2'b00);
            chk_disp($sformatf("blink%0d", i), (i >= 4 && i < 8) ? 8'h01 : 8'h00);
        end

        // Toggle, advance, toggle.
        tick(2'b01);
        tick(2'b01);
        push("no action while held", 8'h00, 8'h00, 3'd0);
        tick(2'b01);
        push("toggle bit0", 8'h01, 8'h00, 3'd0);
        tick(2'b00);
        tick(2'b10);
        tick(2'b10);
        tick(2'b10);
        push("advance", 8'h01, 8'h00, 3'd1);
        tick(2'b00);
        chk_disp("blink cleared on advance", 8'h01);
        tick(2'b01);
        tick(2'b01);
        tick(2'b01);
        chk_disp("still unblinked", 8'h01);
        push("toggle bit1", 8'h03, 8'h00, 3'd1);
        tick(2'b00);
        chk_disp("cursor bit blinks", 8'h01);

        // Cursor walks to 7 and wraps, twice.
        for (int i = 0; i < 7; i++) begin
            tick(2'b10);
            tick(2'b10);
            push($sformatf("walk a%0d", i), 8'h03, 8'h00, 3'((i + 2) % 8));
            tick(2'b00);
            tick(2'b00);
        end
        for (int i = 0; i < 8; i++) begin
            tick(2'b10);
            tick(2'b10);
            push($sformatf("walk b%0d", i), 8'h03, 8'h00, 3'((i + 1) % 8));
            tick(2'b00);
            tick(2'b00);
        end

        // Staggered chord commits once.
        tick(2'b10);
        push("pre-commit advance", 8'h03, 8'h00, 3'd1);
        tick(2'b00);
        tick(2'b01);
        tick(2'b01);
        tick(2'b11);
        tick(2'b11);
        tick(2'b10);
        push("no action mid chord", 8'h03, 8'h00, 3'd1);
        tick(2'b10);
        push("commit", 8'h03, 8'h03, 3'd0);
        exp_valid = 1'b1;
        tick(2'b00);
        push("after commit", 8'h03, 8'h03, 3'd0);
        tick(2'b00);
        tick(2'b00);

        // Long hold aborts; the next one-cycle press still toggles.
        repeat (19) tick(2'b01);
        push("abort held", 8'h03, 8'h03, 3'd0);
        tick(2'b01);
        push("abort release", 8'h03, 8'h03, 3'd0);
        tick(2'b00);
        tick(2'b01);
        push("toggle after abort", 8'h02, 8'h03, 3'd0);
        tick(2'b00);

        // Reset while [1] is held: no advance when it is finally released.
        i_reset = 1'b0;
        tick(2'b10);
        push("reset mid press", 8'h00, 8'h00, 3'd0);
        tick(2'b10);
        i_reset = 1'b1;
        repeat (4) tick(2'b10);
        push("held after reset", 8'h00, 8'h00, 3'd0);
        tick(2'b10);
        push("no advance after reset", 8'h00, 8'h00, 3'd0);
        tick(2'b00);
        tick(2'b10);
        push("advance after reset", 8'h00, 8'h00, 3'd1);
        tick(2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
